// File: rtl/misc_commit_unit.sv
// rtl/misc_commit_unit.sv - misc-pipe commit consumer: holds one result until ROB head, then commits in order
module misc_commit_unit #(
    parameter int ROB_DEPTH = 64,
    parameter int PREG_NUM  = 64,
    parameter int VALEN     = 32,
    localparam int ROB_W    = $clog2(ROB_DEPTH),
    localparam int PREG_W   = $clog2(PREG_NUM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              cmt_valid_i,
    output logic              cmt_ready_o,
    input  logic [1:0]        cmt_kind_i,
    input  logic              cmt_we_i,
    input  logic [31:0]       cmt_wdata_i,
    input  logic [PREG_W-1:0] cmt_pdest_i,
    input  logic [ROB_W-1:0]  cmt_rob_idx_i,
    input  logic              cmt_csr_we_i,
    input  logic [13:0]       cmt_csr_waddr_i,
    input  logic [31:0]       cmt_csr_wdata_i,
    input  logic [VALEN-1:0]  cmt_vaddr_i,
    input  logic [9:0]        cmt_asid_i,
    input  logic [4:0]        cmt_cache_op_i,
    input  logic              cmt_br_redirect_i,
    input  logic [VALEN-1:0]  cmt_br_target_i,
    input  logic [ROB_W-1:0]  rob_head_idx_i,
    output logic              csr_we_o,
    output logic [13:0]       csr_waddr_o,
    output logic [31:0]       csr_wdata_o,
    output logic              side_req_valid_o,
    input  logic              side_req_ready_i,
    output logic              side_req_type_o,
    output logic [VALEN-1:0]  side_req_vaddr_o,
    output logic [9:0]        side_req_asid_o,
    output logic [4:0]        side_req_cacheop_o,
    input  logic              side_done_i,
    output logic              wb_valid_o,
    output logic              wb_we_o,
    output logic [PREG_W-1:0] wb_pdest_o,
    output logic [31:0]       wb_wdata_o,
    output logic [ROB_W-1:0]  wb_rob_idx_o,
    output logic              redirect_valid_o,
    output logic [VALEN-1:0]  redirect_target_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_HEAD = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_FIN       = 3'd4;
    localparam logic [2:0] S_DRAIN     = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [1:0]        kind_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [PREG_W-1:0] pdest_q;
    logic [ROB_W-1:0]  rob_idx_q;
    logic              csr_we_q;
    logic [13:0]       csr_waddr_q;
    logic [31:0]       csr_wdata_q;
    logic [VALEN-1:0]  vaddr_q;
    logic [9:0]        asid_q;
    logic [4:0]        cache_op_q;
    logic              br_redirect_q;
    logic [VALEN-1:0]  br_target_q;

    logic accept;
    logic head_hit;
    logic fin_fire;

    assign cmt_ready_o = (state == S_IDLE) & ~flush_i;
    assign accept      = cmt_valid_i & cmt_ready_o;
    assign head_hit    = (rob_head_idx_i == rob_idx_q);
    // A flush in the FIN cycle cancels every commit side effect.
    assign fin_fire    = (state == S_FIN) & ~flush_i;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_WAIT_HEAD;
            end
            S_WAIT_HEAD: begin
                if (flush_i)       state_nxt = S_IDLE;
                else if (head_hit) state_nxt = kind_q[1] ? S_REQ : S_FIN;
            end
            S_REQ: begin
                // Once the side unit took the request we must still see its done.
                if (flush_i)               state_nxt = side_req_ready_i ? S_DRAIN : S_IDLE;
                else if (side_req_ready_i) state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (flush_i)          state_nxt = side_done_i ? S_IDLE : S_DRAIN;
                else if (side_done_i) state_nxt = S_FIN;
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (side_done_i) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            pdest_q       <= '0;
            rob_idx_q     <= '0;
            csr_we_q      <= 1'b0;
            csr_waddr_q   <= '0;
            csr_wdata_q   <= '0;
            vaddr_q       <= '0;
            asid_q        <= '0;
            cache_op_q    <= '0;
            br_redirect_q <= 1'b0;
            br_target_q   <= '0;
        end else if (accept) begin
            kind_q        <= cmt_kind_i;
            we_q          <= cmt_we_i;
            wdata_q       <= cmt_wdata_i;
            pdest_q       <= cmt_pdest_i;
            rob_idx_q     <= cmt_rob_idx_i;
            csr_we_q      <= cmt_csr_we_i;
            csr_waddr_q   <= cmt_csr_waddr_i;
            csr_wdata_q   <= cmt_csr_wdata_i;
            vaddr_q       <= cmt_vaddr_i;
            asid_q        <= cmt_asid_i;
            cache_op_q    <= cmt_cache_op_i;
            br_redirect_q <= cmt_br_redirect_i;
            br_target_q   <= cmt_br_target_i;
        end
    end

    assign side_req_valid_o   = (state == S_REQ);
    assign side_req_type_o    = kind_q[0];
    assign side_req_vaddr_o   = vaddr_q;
    assign side_req_asid_o    = asid_q;
    assign side_req_cacheop_o = cache_op_q;

    assign wb_valid_o   = fin_fire;
    assign wb_we_o      = fin_fire & we_q;
    assign wb_pdest_o   = pdest_q;
    assign wb_wdata_o   = wdata_q;
    assign wb_rob_idx_o = rob_idx_q;

    // CSR writes are only honoured for CSR-kind ops.
    assign csr_we_o    = fin_fire & csr_we_q & (kind_q == 2'd1);
    assign csr_waddr_o = csr_waddr_q;
    assign csr_wdata_o = csr_wdata_q;

    assign redirect_valid_o  = fin_fire & br_redirect_q;
    assign redirect_target_o = br_target_q;

endmodule
